change_dispenser: RTL
=====================

Name: change_dispenser

Overview:
- Downstream stage of the vending machine. It consumes the machine's `change` request and its leftover credit (in nickel units).
- Pays the credit out as physical coins, largest first (quarter, dime, nickel), by pulsing coin-ejector solenoids and waiting for a chute-sensor confirmation per coin.
- Returns `done` to the vending machine when payout completes, and flags a jam if a coin is never confirmed.

Parameters:
- N, 4, width of `amount` in nickel units; matches the vending machine's amount width.
- PULSE_LEN, 3, cycles each eject line is held high per coin; minimum 1.
- TIMEOUT, 16, maximum WAIT_ACK cycles allowed for `coin_ok` before declaring a jam; minimum 1.

Ports:
- clk  input  1  system clock; all logic on posedge.
- rst  input  1  synchronous, active-high reset.
- change  input  1  payout request from the vending machine; sampled only in IDLE.
- amount  input  N  credit to return, nickel units (nickel=1, dime=2, quarter=5); sampled with `change`.
- coin_ok  input  1  chute sensor; one-cycle pulse per coin that has dropped.
- eject_q  output  1  quarter solenoid drive.
- eject_d  output  1  dime solenoid drive.
- eject_n  output  1  nickel solenoid drive.
- busy  output  1  high in every state except IDLE.
- done  output  1  one-cycle pulse on payout complete; wired to the vending machine's `done`.
- jam  output  1  sticky fault flag.

Behaviour:
- Reset: all outputs 0, state IDLE, `rem` = 0, counters 0. Reset applies mid-operation with the same result, including clearing `jam`. All outputs are registered.
- States are IDLE, SELECT, EJECT, WAIT_ACK, DONE, JAM.
- IDLE:
  - If `change` = 1 at a posedge: `rem` <= `amount`, go to SELECT.
  - Otherwise stay.
  - `coin_ok` is ignored.
- SELECT (1 cycle) chooses the coin:
  - `rem` >= 5 → quarter.
  - else `rem` >= 2 → dime.
  - else `rem` = 1 → nickel.
  - else `rem` = 0 → go to DONE.
  - When a coin is chosen: load the pulse counter with PULSE_LEN and go to EJECT.
- EJECT:
  - Exactly one eject line, for the chosen coin, is high for exactly PULSE_LEN consecutive cycles.
  - Then go to WAIT_ACK with the timeout counter cleared.
  - Eject lines are never simultaneously high.
- WAIT_ACK:
  - All eject lines are low.
  - On `coin_ok` = 1: `rem` <= `rem` − coin value, go to SELECT.
  - If TIMEOUT cycles elapse without `coin_ok`, go to JAM; `rem` is unchanged.
- DONE: `done` = 1 for this single cycle, then IDLE.
- JAM:
  - `jam` = 1, `busy` = 1, eject lines low.
  - Leaves only on `rst`; `change` and `coin_ok` are ignored.
- Busy handling:
  - `change` while `busy` = 1 is ignored; there is no queuing.
  - `change` held high across the DONE→IDLE transition starts a new payout on the first IDLE posedge.
  - The vending machine must drop `change` on `done`.
- `coin_ok` in any state other than WAIT_ACK is ignored; a coin is never double-counted.
- Arithmetic: subtraction occurs only when `rem` >= the coin value, so no underflow is possible. `rem` is N bits wide.
- Cycle timing, with `change` sampled at edge k:
  - Edge k+1: SELECT makes its decision.
  - Eject line high from edge k+2 for PULSE_LEN cycles.
  - Zero-amount case: `done` is high in the cycle after edge k+2.

Optional Feature:
- Macro: CHG_COUNT_EN.
- Defined:
  - Adds output `coin_count [7:0]`, a total count of coins confirmed by `coin_ok` in WAIT_ACK since reset.
  - Saturates at 255.
  - Reset to 0 by `rst`.
- Undefined: port and counter absent; all other behaviour identical.

Test Plan:
- amount=8, change pulse, `coin_ok` 2 cycles after each eject ends → eject_q, eject_d, eject_n each pulse PULSE_LEN=3 cycles, in that order; `done` = 1 for one cycle; `busy` falls with IDLE.
- amount=0, change at edge k → no eject activity; `done` high exactly one cycle after edge k+2.
- amount=7, `coin_ok` withheld after the first quarter → after 16 WAIT_ACK cycles `jam` = 1 and stays 1; `change` then ignored; `rst` clears `jam`, `busy` and `rem`.
- amount=2, `coin_ok` pulsed during EJECT and during IDLE → both ignored; payout completes only on the WAIT_ACK pulse; a single dime is ejected.
- Second `change` (amount=5) asserted while the first payout (amount=5) is in WAIT_ACK → ignored; exactly one quarter is ejected, then `done`. A `rst` asserted mid-EJECT drops the eject line the next cycle.
- CHG_COUNT_EN build: payouts of 8 then 7 → coin_count = 5.

Source files
------------

// File: rtl/change_dispenser.sv
// Coin payout stage: pays a nickel-unit credit as quarters, dimes, then nickels, one confirmed coin at a time.
// Optional build macro CHG_COUNT_EN adds a saturating count of confirmed coins on port coin_count.
module change_dispenser #(
  parameter int N         = 4,
  parameter int PULSE_LEN = 3,
  parameter int TIMEOUT   = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         change,
  input  logic [N-1:0] amount,
  input  logic         coin_ok,
  output logic         eject_q,
  output logic         eject_d,
  output logic         eject_n,
  output logic         busy,
  output logic         done,
  output logic         jam
`ifdef CHG_COUNT_EN
  ,
  output logic [7:0]   coin_count
`endif
);

  localparam int PW = $clog2(PULSE_LEN + 1);
  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {IDLE, SELECT, EJECT, WAIT_ACK, DONE, JAM} state_t;
  typedef enum logic [1:0] {COIN_Q, COIN_D, COIN_N} coin_t;

  function automatic logic [N-1:0] coin_value(input coin_t c);
    case (c)
      COIN_Q:  coin_value = N'(5);
      COIN_D:  coin_value = N'(2);
      COIN_N:  coin_value = N'(1);
      default: coin_value = N'(0);
    endcase
  endfunction

  state_t        state_r, state_s;
  coin_t         coin_r, coin_s;
  logic [N-1:0]  rem_r, rem_s;
  logic [PW-1:0] pcnt_r, pcnt_s;
  logic [TW-1:0] tcnt_r, tcnt_s;
  logic          eject_q_r, eject_d_r, eject_n_r, busy_r, done_r, jam_r;

  // Next-state and datapath decode.
  always_comb begin
    state_s = state_r;
    coin_s  = coin_r;
    rem_s   = rem_r;
    pcnt_s  = pcnt_r;
    tcnt_s  = tcnt_r;
    case (state_r)
      IDLE: begin
        if (change) begin
          rem_s   = amount;
          state_s = SELECT;
        end else begin
          state_s = IDLE;
        end
      end
      SELECT: begin
        pcnt_s = PW'(PULSE_LEN);
        if (rem_r >= N'(5)) begin
          coin_s  = COIN_Q;
          state_s = EJECT;
        end else if (rem_r >= N'(2)) begin
          coin_s  = COIN_D;
          state_s = EJECT;
        end else if (rem_r == N'(1)) begin
          coin_s  = COIN_N;
          state_s = EJECT;
        end else begin
          state_s = DONE;
        end
      end
      EJECT: begin
        if (pcnt_r <= PW'(1)) begin
          tcnt_s  = TW'(0);
          state_s = WAIT_ACK;
        end else begin
          pcnt_s  = pcnt_r - PW'(1);
        end
      end
      WAIT_ACK: begin
        // The chosen coin never exceeds rem, so this cannot underflow.
        if (coin_ok) begin
          rem_s   = rem_r - coin_value(coin_r);
          state_s = SELECT;
        end else if (tcnt_r >= TW'(TIMEOUT - 1)) begin
          state_s = JAM;
        end else begin
          tcnt_s  = tcnt_r + TW'(1);
        end
      end
      DONE:    state_s = IDLE;
      JAM:     state_s = JAM;
      default: state_s = IDLE;
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
      coin_r  <= COIN_Q;
      rem_r   <= N'(0);
      pcnt_r  <= PW'(0);
      tcnt_r  <= TW'(0);
    end else begin
      state_r <= state_s;
      coin_r  <= coin_s;
      rem_r   <= rem_s;
      pcnt_r  <= pcnt_s;
      tcnt_r  <= tcnt_s;
    end
  end

  // Outputs are registered from the current state, so they trail it by one cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      eject_q_r <= 1'b0;
      eject_d_r <= 1'b0;
      eject_n_r <= 1'b0;
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
      jam_r     <= 1'b0;
    end else begin
      eject_q_r <= (state_r == EJECT) && (coin_r == COIN_Q);
      eject_d_r <= (state_r == EJECT) && (coin_r == COIN_D);
      eject_n_r <= (state_r == EJECT) && (coin_r == COIN_N);
      busy_r    <= (state_r != IDLE);
      done_r    <= (state_r == DONE);
      jam_r     <= (state_r == JAM);
    end
  end

  assign eject_q = eject_q_r;
  assign eject_d = eject_d_r;
  assign eject_n = eject_n_r;
  assign busy    = busy_r;
  assign done    = done_r;
  assign jam     = jam_r;

`ifdef CHG_COUNT_EN
  logic [7:0] coin_count_r;

  // Saturating count of coins confirmed while waiting for the chute sensor.
  always_ff @(posedge clk) begin
    if (rst) begin
      coin_count_r <= 8'd0;
    end else if ((state_r == WAIT_ACK) && coin_ok && (coin_count_r != 8'd255)) begin
      coin_count_r <= coin_count_r + 8'd1;
    end else begin
      coin_count_r <= coin_count_r;
    end
  end

  assign coin_count = coin_count_r;
`endif

endmodule
